// File: rtl/button_pkg.sv
// Shared definitions for the push-button gesture controller: event codes,
// controller state encoding and the millisecond counter ceiling.
package button_pkg;

   typedef logic [1:0] evt_code_t;

   localparam evt_code_t EVT_NONE   = 2'b00;
   localparam evt_code_t EVT_SINGLE = 2'b01;
   localparam evt_code_t EVT_DOUBLE = 2'b10;
   localparam evt_code_t EVT_LONG   = 2'b11;

   localparam logic [15:0] MS_SAT = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESSED,
      ST_LONG_HELD,
      ST_WAIT_SECOND,
      ST_SECOND_PRESSED
   } gesture_state_t;

endpackage

// File: rtl/button_gesture_ctrl_if.sv
// Event handshake between the gesture controller (master) and its consumer.
interface button_gesture_ctrl_if;
   import button_pkg::*;

   logic      evt_valid;
   evt_code_t evt_code;
   logic      evt_ready;
   logic      evt_dropped;

   modport master (output evt_valid, output evt_code, output evt_dropped, input evt_ready);
   modport slave  (input evt_valid, input evt_code, input evt_dropped, output evt_ready);

endinterface

// File: rtl/debounce_ip_core.sv
// Debouncer: two-flop synchroniser, one sample stage, then a stability counter.
// The level only flips after the sampled pin has differed from it for
// CLK_FREQ_HZ/2000 + 1 consecutive cycles; change pulses for one cycle then.
module debounce_ip_core #(
   parameter int CLK_FREQ_HZ = 10_000_000,
   parameter bit IS_PULLUP   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic change
);

   localparam int STABLE = (CLK_FREQ_HZ / 2000 > 0) ? CLK_FREQ_HZ / 2000 : 1;
   localparam int CW     = $clog2(STABLE + 1);

   logic [1:0]    sync;
   logic          sample;
   logic [CW-1:0] cnt;

   // Synchronise the raw pin and normalise it so that 1 always means pressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync   <= {2{IS_PULLUP}};
         sample <= 1'b0;
      end else begin
         sync   <= {sync[0], raw};
         sample <= sync[1] ^ IS_PULLUP;
      end
   end

   // Accept a new level only after it has been held long enough.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level  <= 1'b0;
         change <= 1'b0;
         cnt    <= '0;
      end else if (sample != level) begin
         if (cnt == CW'(STABLE)) begin
            level  <= sample;
            change <= 1'b1;
            cnt    <= '0;
         end else begin
            change <= 1'b0;
            cnt    <= cnt + CW'(1);
         end
      end else begin
         change <= 1'b0;
         cnt    <= '0;
      end
   end

endmodule

// File: rtl/button_gesture_ctrl.sv
// Push-button gesture controller: classifies debounced presses into SINGLE,
// DOUBLE and LONG events and offers them through a one-entry valid/ready slot.
module button_gesture_ctrl
   import button_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 10_000_000,
   parameter bit IS_PULLUP   = 1'b0,
   parameter int LONG_MS     = 800,
   parameter int DOUBLE_MS   = 300
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push_button,
   output logic                 pressed,
   button_gesture_ctrl_if.master evt
);

   localparam int TICK_DIV = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
   localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic           deb_level;
   logic           deb_change;
   logic           press_edge;
   logic           release_edge;
   logic [PW-1:0]  prescale;
   logic [15:0]    ms_cnt;
   logic           tick;
   logic           long_hit;
   logic           dbl_hit;
   gesture_state_t state_q;
   gesture_state_t state_d;
   logic           emit;
   evt_code_t      emit_code;
   logic           slot_valid;
   evt_code_t      slot_code;
   logic           drop_pulse;
   logic           handshake;

   debounce_ip_core #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .IS_PULLUP   (IS_PULLUP)
   ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (push_button),
      .level  (deb_level),
      .change (deb_change)
   );

   assign press_edge   = deb_change & deb_level;
   assign release_edge = deb_change & ~deb_level;

   // Timeouts fire on the tick that carries the ms counter up to the limit.
   assign tick     = (prescale == PW'(TICK_DIV - 1));
   assign long_hit = tick && (ms_cnt == 16'(LONG_MS - 1));
   assign dbl_hit  = tick && (ms_cnt == 16'(DOUBLE_MS - 1));

   // Registered copy of the debounced level for the application.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pressed <= 1'b0;
      else        pressed <= deb_level;
   end

   // Millisecond timer, restarted whenever the controller changes state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale <= '0;
         ms_cnt   <= '0;
      end else if (state_d != state_q) begin
         prescale <= '0;
         ms_cnt   <= '0;
      end else if (tick) begin
         prescale <= '0;
         if (ms_cnt != MS_SAT) ms_cnt <= ms_cnt + 16'd1;
      end else begin
         prescale <= prescale + PW'(1);
      end
   end

   // Gesture state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Gesture classification; LONG beats a simultaneous release, while a
   // second press beats a simultaneous double-click timeout.
   always_comb begin
      state_d   = state_q;
      emit      = 1'b0;
      emit_code = EVT_NONE;
      case (state_q)
         ST_IDLE: begin
            if (press_edge) state_d = ST_PRESSED;
         end
         ST_PRESSED: begin
            if (long_hit) begin
               emit      = 1'b1;
               emit_code = EVT_LONG;
               state_d   = ST_LONG_HELD;
            end else if (release_edge) begin
               state_d = ST_WAIT_SECOND;
            end
         end
         ST_LONG_HELD: begin
            if (release_edge) state_d = ST_IDLE;
         end
         ST_WAIT_SECOND: begin
            if (press_edge) begin
               state_d = ST_SECOND_PRESSED;
            end else if (dbl_hit) begin
               emit      = 1'b1;
               emit_code = EVT_SINGLE;
               state_d   = ST_IDLE;
            end
         end
         ST_SECOND_PRESSED: begin
            if (release_edge) begin
               emit      = 1'b1;
               emit_code = EVT_DOUBLE;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign handshake = slot_valid & evt.evt_ready;

   // One-entry event slot; a new event is dropped only if the slot stays full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid <= 1'b0;
         slot_code  <= EVT_NONE;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= 1'b0;
         if (emit) begin
            if (!slot_valid || handshake) begin
               slot_valid <= 1'b1;
               slot_code  <= emit_code;
            end else begin
               drop_pulse <= 1'b1;
            end
         end else if (handshake) begin
            slot_valid <= 1'b0;
            slot_code  <= EVT_NONE;
         end
      end
   end

   assign evt.evt_valid   = slot_valid;
   assign evt.evt_code    = slot_code;
   assign evt.evt_dropped = drop_pulse;

endmodule

// File: tb/tb_button_gesture_ctrl.sv
// Bench for button_gesture_ctrl: pin waveforms are built from segments, a
// gesture-level model predicts every output per cycle, and the DUT is compared
// against it on each falling clock edge.
module tb_button_gesture_ctrl;
   import button_pkg::*;

   localparam int CLK_FREQ_HZ = 10_000;
   localparam int LONG_MS     = 8;
   localparam int DOUBLE_MS   = 3;
   localparam int TICK        = CLK_FREQ_HZ / 1000;
   localparam int STABLE      = CLK_FREQ_HZ / 2000;
   localparam int LONG_CYC    = LONG_MS * TICK;
   localparam int DBL_CYC     = DOUBLE_MS * TICK;
   localparam int PIPE        = 4;
   localparam int MAXL        = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic push_button = 1'b0;
   logic pressed;

   button_gesture_ctrl_if evt_bus ();

   button_gesture_ctrl #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .IS_PULLUP   (1'b0),
      .LONG_MS     (LONG_MS),
      .DOUBLE_MS   (DOUBLE_MS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_button (push_button),
      .pressed     (pressed),
      .evt         (evt_bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   bit        wave [MAXL];
   bit        rdy [MAXL];
   int        len;
   bit        exp_pressed [MAXL];
   bit        exp_valid [MAXL];
   bit        exp_drop [MAXL];
   logic [1:0] exp_code [MAXL];
   bit        emit_at [MAXL];
   logic [1:0] emit_code_at [MAXL];
   int        edge_t[$];

   task automatic checkOutput(input string tag, input int cyc, input logic [1:0] obs, input logic [1:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
      end
   endtask

   task automatic addSeg(input bit v, input int n);
      for (int i = 0; i < n; i++) begin
         if (len < MAXL) begin
            wave[len] = v;
            rdy[len]  = 1'b0;
            len++;
         end
      end
   endtask

   task automatic randomReady();
      for (int i = 0; i < len; i++) rdy[i] = ($urandom_range(3) == 0);
   endtask

   task automatic readyTail();
      for (int i = len - 5; i < len; i++) rdy[i] = 1'b1;
   endtask

   task automatic addEmit(input int t, input logic [1:0] code);
      if (t >= 0 && t < MAXL) begin
         emit_at[t]      = 1'b1;
         emit_code_at[t] = code;
      end
   endtask

   // Predict debounced edges, gestures and the event slot from the waveform.
   task automatic buildModel();
      int level, run, j, i, n, p, r;
      bit v;
      logic [1:0] code;
      edge_t.delete();
      level = 0;
      run = 0;
      for (int k = 0; k < len; k++) begin
         if (int'(wave[k]) != level) run++;
         else run = 0;
         if (run == STABLE + 1) begin
            level = int'(wave[k]);
            run = 0;
            edge_t.push_back(k + PIPE);
         end
      end
      j = 0;
      for (int c = 0; c < len; c++) begin
         while (j < edge_t.size() && edge_t[j] + 1 <= c) j++;
         exp_pressed[c] = (j % 2 == 1);
      end
      for (int c = 0; c < MAXL; c++) begin
         emit_at[c] = 1'b0;
         emit_code_at[c] = EVT_NONE;
      end
      n = edge_t.size();
      i = 0;
      while (i < n) begin
         p = edge_t[i];
         if (i + 1 >= n) begin
            addEmit(p + LONG_CYC, EVT_LONG);
            i = n;
         end else begin
            r = edge_t[i + 1];
            if (r >= p + LONG_CYC) begin
               addEmit(p + LONG_CYC, EVT_LONG);
               i += (r == p + LONG_CYC) ? 4 : 2;
            end else if (i + 2 < n && edge_t[i + 2] <= r + DBL_CYC) begin
               if (i + 3 < n) addEmit(edge_t[i + 3], EVT_DOUBLE);
               i += 4;
            end else begin
               addEmit(r + DBL_CYC, EVT_SINGLE);
               i += 2;
            end
         end
      end
      v = 1'b0;
      code = EVT_NONE;
      exp_valid[0] = 1'b0;
      exp_code[0]  = EVT_NONE;
      exp_drop[0]  = 1'b0;
      for (int c = 1; c < len; c++) begin
         exp_drop[c] = 1'b0;
         if (emit_at[c - 1]) begin
            if (!v || rdy[c - 1]) begin
               v = 1'b1;
               code = emit_code_at[c - 1];
            end else begin
               exp_drop[c] = 1'b1;
            end
         end else if (v && rdy[c - 1]) begin
            v = 1'b0;
            code = EVT_NONE;
         end
         exp_valid[c] = v;
         exp_code[c]  = code;
      end
   endtask

   // Play the waveform, checking all outputs each cycle; stops early at abort_at.
   task automatic applyStimulus(input int abort_at);
      buildModel();
      for (int c = 0; c < len; c++) begin
         checkOutput("pressed", c, {1'b0, pressed}, {1'b0, exp_pressed[c]});
         checkOutput("evt_valid", c, {1'b0, evt_bus.evt_valid}, {1'b0, exp_valid[c]});
         checkOutput("evt_code", c, evt_bus.evt_code, exp_code[c]);
         checkOutput("evt_dropped", c, {1'b0, evt_bus.evt_dropped}, {1'b0, exp_drop[c]});
         if (c == abort_at) break;
         push_button = wave[c];
         evt_bus.evt_ready = rdy[c];
         @(negedge clk);
      end
   endtask

   initial begin
      int npress, hi;
      evt_bus.evt_ready = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_valid", 0, {1'b0, evt_bus.evt_valid}, 2'b00);
      checkOutput("reset_code", 0, evt_bus.evt_code, EVT_NONE);
      checkOutput("reset_dropped", 0, {1'b0, evt_bus.evt_dropped}, 2'b00);
      checkOutput("reset_pressed", 0, {1'b0, pressed}, 2'b00);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] single press");
      len = 0; addSeg(1, 20); addSeg(0, 140); readyTail(); applyStimulus(-1);

      $display("[TB] double press");
      len = 0; addSeg(1, 20); addSeg(0, 10); addSeg(1, 20); addSeg(0, 140); readyTail(); applyStimulus(-1);

      $display("[TB] long hold");
      len = 0; addSeg(1, 120); addSeg(0, 140); readyTail(); applyStimulus(-1);

      $display("[TB] long pending then single, slot full");
      len = 0; addSeg(1, 120); addSeg(0, 30); addSeg(1, 20); addSeg(0, 140); readyTail(); applyStimulus(-1);

      $display("[TB] bouncing pin");
      len = 0; addSeg(1, 5); addSeg(0, 5); addSeg(1, 40); addSeg(0, 3); addSeg(1, 3); addSeg(0, 140);
      readyTail(); applyStimulus(-1);

      $display("[TB] timing boundaries");
      len = 0; addSeg(1, LONG_CYC - 1); addSeg(0, 140); readyTail(); applyStimulus(-1);
      len = 0; addSeg(1, LONG_CYC + 1); addSeg(0, 140); readyTail(); applyStimulus(-1);
      len = 0; addSeg(1, LONG_CYC); addSeg(0, 20); addSeg(1, 20); addSeg(0, 140); readyTail(); applyStimulus(-1);
      len = 0; addSeg(1, 20); addSeg(0, DBL_CYC); addSeg(1, 20); addSeg(0, 140); readyTail(); applyStimulus(-1);
      len = 0; addSeg(1, 20); addSeg(0, DBL_CYC + 1); addSeg(1, 20); addSeg(0, 140); readyTail(); applyStimulus(-1);

      $display("[TB] randomized gestures");
      for (int s = 0; s < 25; s++) begin
         len = 0;
         npress = int'($urandom_range(3, 1));
         for (int k = 0; k < npress; k++) begin
            hi = int'($urandom_range(110, 6));
            if (hi == LONG_CYC) hi = LONG_CYC + 2;
            addSeg(1, hi);
            if (k < npress - 1) addSeg(0, int'($urandom_range(45, 6)));
         end
         addSeg(0, 140);
         randomReady();
         readyTail();
         applyStimulus(-1);
      end

      $display("[TB] reset during press");
      len = 0; addSeg(1, 20); addSeg(0, 60); addSeg(1, 200); readyTail();
      applyStimulus(139);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", 0, {1'b0, evt_bus.evt_valid}, 2'b00);
      checkOutput("async_rst_code", 0, evt_bus.evt_code, EVT_NONE);
      checkOutput("async_rst_dropped", 0, {1'b0, evt_bus.evt_dropped}, 2'b00);
      checkOutput("async_rst_pressed", 0, {1'b0, pressed}, 2'b00);
      evt_bus.evt_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push_button = 1'b0;
      @(negedge clk);
      len = 0; addSeg(0, 200); applyStimulus(-1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/button_gesture_ctrl.md
# button_gesture_ctrl

Gesture controller for a single push button: debounces the raw pin and classifies the settled presses into SINGLE, DOUBLE and LONG events. Each event is delivered to downstream logic (LED mode sequencer, menu logic) over a valid/ready handshake. Sits between the board pin and application FSMs, replacing direct use of debouncer outputs.

## Interface
- CLK_FREQ_HZ, 10_000_000, system clock frequency; TICK_DIV = CLK_FREQ_HZ/1000 cycles per ms tick
- IS_PULLUP, 0, 1 = pin idles high (pressed = 0); 0 = pin idles low (pressed = 1)
- LONG_MS, 800, hold time in ms that makes a LONG event (1..65535)
- DOUBLE_MS, 300, max release-to-second-press gap in ms for DOUBLE (1..65535)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- push_button  in  1  raw asynchronous pin
- evt_valid  out  1  event pending
- evt_code  out  2  01 SINGLE, 10 DOUBLE, 11 LONG; 00 when evt_valid = 0
- evt_ready  in  1  consumer accepts event when evt_valid & evt_ready
- evt_dropped  out  1  one-cycle pulse: event generated while slot still full, new event discarded
- pressed  out  1  debounced level normalised to 1 = pressed

## Operation
- Debouncer instance supplies level + one-cycle change pulse; press edge = change pulse with normalised level 1, release edge = change pulse with level 0.
- ms counter (16 bit) + prescaler (clog2(TICK_DIV) bits); both cleared on every state transition; prescaler wrap at TICK_DIV-1 increments ms counter; ms counter saturates at 65535.
- States:
  - IDLE: press edge -> PRESSED.
  - PRESSED: ms counter reaches LONG_MS -> emit LONG, -> LONG_HELD; release edge first -> WAIT_SECOND.
  - LONG_HELD: release edge -> IDLE, no event.
  - WAIT_SECOND: press edge -> SECOND_PRESSED; ms counter reaches DOUBLE_MS -> emit SINGLE, -> IDLE.
  - SECOND_PRESSED: release edge -> emit DOUBLE, -> IDLE (hold length ignored).
- Same-cycle timeout and edge: edge wins in WAIT_SECOND (DOUBLE path); timeout wins in PRESSED (LONG).
- Event slot: one entry. Emit with slot empty -> evt_valid = 1, evt_code loaded. Emit with slot full and no handshake that cycle -> event discarded, evt_dropped pulses, pending event unchanged. Handshake and emit in same cycle -> new event loaded, no drop.
- evt_code, evt_valid stable while evt_valid & !evt_ready.

## Timing
- Reset values: evt_valid 0, evt_code 00, evt_dropped 0, pressed 0, state IDLE, counters 0.
- Pin-to-pressed: 2 sync + shift + CLK_FREQ_HZ/2000 stable cycles of debouncer, +1 register.
- LONG: evt_valid rises LONG_MS*TICK_DIV + 1 cycles after the press-edge cycle.
- SINGLE: evt_valid rises DOUBLE_MS*TICK_DIV + 1 cycles after the release-edge cycle.
- DOUBLE: evt_valid rises 1 cycle after the second release edge.
- Handshake: evt_valid falls the cycle after evt_valid & evt_ready sampled high.
- Reset mid-gesture: state, slot and counters cleared immediately; no event emitted after deassert until a fresh press edge.

## Structure
- Shared package/include button_pkg: event code constants (EVT_NONE, EVT_SINGLE, EVT_DOUBLE, EVT_LONG), state encodings.
- Sub-module: debounce_ip_core, instanced with CLK_FREQ_HZ and IS_PULLUP passed through; rst_n shared.
- Controller: one FSM + timer + single-entry event register, ~200 RTL lines.

## Test plan
- CLK_FREQ_HZ=10_000, LONG_MS=8, DOUBLE_MS=3, IS_PULLUP=0 for all; press 2 ms, release, idle 10 ms -> SINGLE (01) exactly 31 cycles after release edge, held until evt_ready.
- Press 2 ms, release 1 ms, press 2 ms, release -> DOUBLE (10) one cycle after second release edge; no SINGLE.
- Hold 12 ms -> LONG (11) 81 cycles after press edge; release produces no further event.
- Leave LONG pending with evt_ready=0, perform SINGLE gesture -> evt_dropped one pulse, evt_code stays 11; then ready -> valid drops next cycle.
- Bounce pin at 5-cycle intervals for 1 ms, then stable high -> exactly one press edge; pressed rises after debounce latency.
- Assert rst_n low during PRESSED at 5 ms -> all outputs 0 asynchronously; release after reset -> no event.
